data_memory_responder: RTL and testbench

Synthesizable data-memory endpoint that answers the GPU's external data-memory interface: the responder side of the valid/ready read and write handshake driven by the memory controller.
- Holds a 2^ADDR_BITS x DATA_BITS array with separate, independent read and write channels, each with a programmable fixed latency.
- Used as the memory model in system simulation and as on-chip data RAM in FPGA builds.
- Side-band load port lets the bench or host preload contents; transaction counters support verification.

---
 rtl/data_memory_responder.sv | 210 +++++++++++++++++++++
 tb/tb_data_memory_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
//   Data-memory endpoint answering the valid/ready read and write handshake of
//   an external memory controller. It holds a 2^ADDR_BITS x DATA_BITS array.
//   The read and write channels are independent, and each one completes a
//   request a fixed number of cycles after accepting it.
//
// Ports
//   clk                rising-edge clock
//   reset              asynchronous, active-high; clears FSMs, outputs, counters
//                      and every array word
//   mem_read_valid     read request, held by the requester until ready is seen
//   mem_read_address   read address, latched at accept
//   mem_read_ready     one-cycle read-complete pulse
//   mem_read_data      read data; holds until the next read response
//   mem_write_valid    write request, held by the requester until ready is seen
//   mem_write_address  write address, latched at accept
//   mem_write_data     write data, latched at accept
//   mem_write_ready    one-cycle write-complete pulse (array updated same edge)
//   load_enable        side-band direct write, any time
//   load_address       side-band address
//   load_data          side-band data
//   read_count         completed reads, saturating at 0xFFFF
//   write_count        completed writes, saturating at 0xFFFF
// -----------------------------------------------------------------------------
module data_memory_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read_valid,
  input  logic [ADDR_BITS-1:0] mem_read_address,
  output logic                 mem_read_ready,
  output logic [DATA_BITS-1:0] mem_read_data,
  input  logic                 mem_write_valid,
  input  logic [ADDR_BITS-1:0] mem_write_address,
  input  logic [DATA_BITS-1:0] mem_write_data,
  output logic                 mem_write_ready,
  input  logic                 load_enable,
  input  logic [ADDR_BITS-1:0] load_address,
  input  logic [DATA_BITS-1:0] load_data,
  output logic [15:0]          read_count,
  output logic [15:0]          write_count
);

  localparam int          DEPTH   = 1 << ADDR_BITS;
  localparam logic [3:0]  RD_LAT  = 4'(READ_LATENCY);
  localparam logic [3:0]  WR_LAT  = 4'(WRITE_LATENCY);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t               r_rd_state;
  state_t               r_wr_state;
  logic [3:0]           r_rd_cnt;
  logic [3:0]           r_wr_cnt;
  logic [ADDR_BITS-1:0] r_rd_addr;
  logic [ADDR_BITS-1:0] r_wr_addr;
  logic [DATA_BITS-1:0] r_wr_data;
  logic                 r_rd_ready;
  logic                 r_wr_ready;
  logic [DATA_BITS-1:0] r_rd_data;
  logic [15:0]          r_read_count;
  logic [15:0]          r_write_count;
  logic [DATA_BITS-1:0] r_mem [DEPTH];

  // A channel fires on the edge that enters RESP: either straight from IDLE
  // when the latency is zero, or at the last WAIT count. With zero latency
  // the request fields have not been latched yet, so the live inputs are used.
  logic                 w_rd_fire;
  logic                 w_wr_fire;
  logic [ADDR_BITS-1:0] w_rd_fire_addr;
  logic [ADDR_BITS-1:0] w_wr_fire_addr;
  logic [DATA_BITS-1:0] w_wr_fire_data;

  assign w_rd_fire = ((r_rd_state == ST_IDLE) && mem_read_valid && (RD_LAT == 4'd0)) ||
                     ((r_rd_state == ST_WAIT) && (r_rd_cnt <= 4'd1));
  assign w_wr_fire = ((r_wr_state == ST_IDLE) && mem_write_valid && (WR_LAT == 4'd0)) ||
                     ((r_wr_state == ST_WAIT) && (r_wr_cnt <= 4'd1));

  assign w_rd_fire_addr = (r_rd_state == ST_IDLE) ? mem_read_address  : r_rd_addr;
  assign w_wr_fire_addr = (r_wr_state == ST_IDLE) ? mem_write_address : r_wr_addr;
  assign w_wr_fire_data = (r_wr_state == ST_IDLE) ? mem_write_data    : r_wr_data;

  assign mem_read_ready  = r_rd_ready;
  assign mem_read_data   = r_rd_data;
  assign mem_write_ready = r_wr_ready;
  assign read_count      = r_read_count;
  assign write_count     = r_write_count;

  // Read channel: handshake FSM, response data capture and completion count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_state   <= ST_IDLE;
      r_rd_cnt     <= 4'd0;
      r_rd_addr    <= '0;
      r_rd_ready   <= 1'b0;
      r_rd_data    <= '0;
      r_read_count <= 16'd0;
    end else begin
      r_rd_ready <= w_rd_fire;
      // The array is sampled before this edge's write or load lands, so a
      // same-edge collision returns the old word.
      if (w_rd_fire) begin
        r_rd_data <= r_mem[w_rd_fire_addr];
        if (r_read_count != CNT_MAX) begin
          r_read_count <= r_read_count + 16'd1;
        end else begin
          r_read_count <= r_read_count;
        end
      end else begin
        r_rd_data <= r_rd_data;
      end
      case (r_rd_state)
        ST_IDLE: begin
          if (mem_read_valid) begin
            r_rd_addr  <= mem_read_address;
            r_rd_cnt   <= RD_LAT;
            r_rd_state <= (RD_LAT == 4'd0) ? ST_RESP : ST_WAIT;
          end else begin
            r_rd_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          // Dropping valid here does not abort: the response still completes.
          if (w_rd_fire) begin
            r_rd_state <= ST_RESP;
          end else begin
            r_rd_cnt <= r_rd_cnt - 4'd1;
          end
        end
        ST_RESP: r_rd_state <= mem_read_valid ? ST_HOLD : ST_IDLE;
        // Wait for the requester to drop valid so one request is served once.
        ST_HOLD: r_rd_state <= mem_read_valid ? ST_HOLD : ST_IDLE;
        default: r_rd_state <= ST_IDLE;
      endcase
    end
  end

  // Write channel: handshake FSM, request capture and completion count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_state    <= ST_IDLE;
      r_wr_cnt      <= 4'd0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_wr_ready    <= 1'b0;
      r_write_count <= 16'd0;
    end else begin
      r_wr_ready <= w_wr_fire;
      if (w_wr_fire) begin
        if (r_write_count != CNT_MAX) begin
          r_write_count <= r_write_count + 16'd1;
        end else begin
          r_write_count <= r_write_count;
        end
      end else begin
        r_write_count <= r_write_count;
      end
      case (r_wr_state)
        ST_IDLE: begin
          if (mem_write_valid) begin
            r_wr_addr  <= mem_write_address;
            r_wr_data  <= mem_write_data;
            r_wr_cnt   <= WR_LAT;
            r_wr_state <= (WR_LAT == 4'd0) ? ST_RESP : ST_WAIT;
          end else begin
            r_wr_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (w_wr_fire) begin
            r_wr_state <= ST_RESP;
          end else begin
            r_wr_cnt <= r_wr_cnt - 4'd1;
          end
        end
        ST_RESP: r_wr_state <= mem_write_valid ? ST_HOLD : ST_IDLE;
        ST_HOLD: r_wr_state <= mem_write_valid ? ST_HOLD : ST_IDLE;
        default: r_wr_state <= ST_IDLE;
      endcase
    end
  end

  // Storage array: write-channel commit, then side-band load, which takes
  // priority when both target the same word on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr_fire) begin
        r_mem[w_wr_fire_addr] <= w_wr_fire_data;
      end
      if (load_enable) begin
        r_mem[load_address] <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_data_memory_responder
//   Self-checking bench. "dut" runs with read/write latency 2 and "dut0" runs
//   with latency 0. A vector table and hand-written sequences cover reset,
//   handshake timing, collisions, aborts and counter saturation. A randomized
//   phase on "dut" is checked against a transaction-level model: an array of
//   words, the due cycle of each outstanding request and the counter totals.
// -----------------------------------------------------------------------------
module tb_data_memory_responder;

  localparam int RL = 2;
  localparam int WL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rv, wv, le;
  logic [7:0]  ra, wa, wd, la, ld;
  logic        rr, wr;
  logic [7:0]  rd_o;
  logic [15:0] rc, wc;

  logic        z_rv, z_wv, z_le;
  logic [7:0]  z_ra, z_wa, z_wd, z_la, z_ld;
  logic        z_rr, z_wr;
  logic [7:0]  z_rd;
  logic [15:0] z_rc, z_wc;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  mm [256];
  logic [15:0] exp_rc, exp_wc;
  logic [7:0]  last_rd;

  always #5 clk = ~clk;

  data_memory_responder #(.ADDR_BITS(8), .DATA_BITS(8), .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
    .clk(clk), .reset(rst),
    .mem_read_valid(rv), .mem_read_address(ra), .mem_read_ready(rr), .mem_read_data(rd_o),
    .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd), .mem_write_ready(wr),
    .load_enable(le), .load_address(la), .load_data(ld),
    .read_count(rc), .write_count(wc)
  );

  data_memory_responder #(.ADDR_BITS(8), .DATA_BITS(8), .READ_LATENCY(0), .WRITE_LATENCY(0)) dut0 (
    .clk(clk), .reset(rst),
    .mem_read_valid(z_rv), .mem_read_address(z_ra), .mem_read_ready(z_rr), .mem_read_data(z_rd),
    .mem_write_valid(z_wv), .mem_write_address(z_wa), .mem_write_data(z_wd), .mem_write_ready(z_wr),
    .load_enable(z_le), .load_address(z_la), .load_data(z_ld),
    .read_count(z_rc), .write_count(z_wc)
  );

  typedef struct {
    logic [1:0] op;    // 0 load, 1 write, 2 read
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] expd;
    logic       hold;  // keep valid one extra cycle after ready
    logic       drop;  // drop valid right after accept
  } vec_t;

  vec_t vt[8];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    le = 1'b1; la = a; ld = d;
    @(negedge clk);
    le = 1'b0;
    mm[a] = d;
  endtask

  // One read or write on the latency-2 instance; checks pulse timing, data,
  // absence of a second pulse and the counters.
  task automatic xact(input logic is_wr, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] expd, input logic hold, input logic drop, input string nm);
    int n;
    bit seen;
    @(negedge clk);
    if (is_wr) begin wv = 1'b1; wa = a; wd = d; end
    else       begin rv = 1'b1; ra = a; end
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = is_wr ? wr : rr;
      if (n == 1) begin
        // Request fields change after accept and must be ignored.
        ra = ~a; wa = ~a; wd = ~d;
        if (drop) begin rv = 1'b0; wv = 1'b0; end
      end
    end
    chk({nm, "-latency"}, 32'(n), 32'((is_wr ? WL : RL) + 1));
    if (is_wr) begin
      mm[a] = d;
      exp_wc = sat_inc(exp_wc);
    end else begin
      chk({nm, "-data"}, 32'(rd_o), 32'(expd));
      last_rd = expd;
      exp_rc = sat_inc(exp_rc);
    end
    if (!hold) begin rv = 1'b0; wv = 1'b0; end
    @(negedge clk);
    chk({nm, "-pulse1"}, 32'(is_wr ? wr : rr), 32'd0);
    rv = 1'b0; wv = 1'b0;
    @(negedge clk);
    chk({nm, "-pulse2"}, 32'(is_wr ? wr : rr), 32'd0);
    chk({nm, "-rcount"}, 32'(rc), 32'(exp_rc));
    chk({nm, "-wcount"}, 32'(wc), 32'(exp_wc));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rv = 1'b0; wv = 1'b0; le = 1'b0; ra = 8'h00; wa = 8'h00; wd = 8'h00; la = 8'h00; ld = 8'h00;
    z_rv = 1'b0; z_wv = 1'b0; z_le = 1'b0; z_ra = 8'h00; z_wa = 8'h00; z_wd = 8'h00;
    z_la = 8'h00; z_ld = 8'h00;
    for (int i = 0; i < 256; i++) mm[i] = 8'h00;
    exp_rc = 16'd0; exp_wc = 16'd0; last_rd = 8'h00;

    vt[0] = '{2'd0, 8'h05, 8'h3C, 8'h00, 1'b0, 1'b0};
    vt[1] = '{2'd2, 8'h05, 8'h00, 8'h3C, 1'b1, 1'b0};
    vt[2] = '{2'd1, 8'h20, 8'h7E, 8'h00, 1'b0, 1'b0};
    vt[3] = '{2'd2, 8'h20, 8'h00, 8'h7E, 1'b0, 1'b0};
    vt[4] = '{2'd1, 8'h21, 8'h5A, 8'h00, 1'b0, 1'b1};
    vt[5] = '{2'd2, 8'h21, 8'h00, 8'h5A, 1'b0, 1'b1};
    vt[6] = '{2'd1, 8'h05, 8'hC3, 8'h00, 1'b1, 1'b0};
    vt[7] = '{2'd2, 8'h05, 8'h00, 8'hC3, 1'b0, 1'b0};

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    chk("rst-rready", 32'(rr), 32'd0);
    chk("rst-wready", 32'(wr), 32'd0);
    chk("rst-rdata", 32'(rd_o), 32'd0);
    chk("rst-rcount", 32'(rc), 32'd0);
    chk("rst-wcount", 32'(wc), 32'd0);
    chk("rst0-counts", 32'({z_rc, z_wc}), 32'd0);
    rst = 1'b0;

    // Reset in the middle of a write's WAIT: no pulse, no commit.
    @(negedge clk);
    wv = 1'b1; wa = 8'h10; wd = 8'hAA;
    @(negedge clk);
    chk("midrst-wait", 32'(wr), 32'd0);
    rst = 1'b1; wv = 1'b0;
    @(negedge clk);
    chk("midrst-held", 32'(wr), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst-nopulse", 32'(wr), 32'd0);
    end
    chk("midrst-wcount", 32'(wc), 32'd0);
    chk("midrst-rcount", 32'(rc), 32'd0);
    xact(1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0, "midrst-read10");

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      if (vt[i].op == 2'd0) do_load(vt[i].a, vt[i].d);
      else xact(vt[i].op == 2'd1, vt[i].a, vt[i].d, vt[i].expd, vt[i].hold, vt[i].drop, $sformatf("vec%0d", i));
    end

    // Same-edge read capture and write commit: read returns the old word.
    do_load(8'h30, 8'h11);
    @(negedge clk);
    rv = 1'b1; ra = 8'h30; wv = 1'b1; wa = 8'h30; wd = 8'h22;
    repeat (3) @(negedge clk);
    chk("coll-rready", 32'(rr), 32'd1);
    chk("coll-wready", 32'(wr), 32'd1);
    chk("coll-olddata", 32'(rd_o), 32'h11);
    rv = 1'b0; wv = 1'b0;
    mm[8'h30] = 8'h22; last_rd = 8'h11; exp_rc = sat_inc(exp_rc); exp_wc = sat_inc(exp_wc);
    @(negedge clk);
    chk("coll-after", 32'({rr, wr}), 32'd0);
    xact(1'b0, 8'h30, 8'h00, 8'h22, 1'b0, 1'b0, "coll-newdata");

    // Load on the commit edge wins over the write.
    @(negedge clk);
    rv = 1'b1; ra = 8'h30; wv = 1'b1; wa = 8'h30; wd = 8'h44;
    @(negedge clk);
    @(negedge clk);
    le = 1'b1; la = 8'h30; ld = 8'h33;
    @(negedge clk);
    le = 1'b0;
    chk("collld-ready", 32'({rr, wr}), 32'd3);
    chk("collld-rdata", 32'(rd_o), 32'h22);
    rv = 1'b0; wv = 1'b0;
    mm[8'h30] = 8'h33; last_rd = 8'h22; exp_rc = sat_inc(exp_rc); exp_wc = sat_inc(exp_wc);
    @(negedge clk);
    xact(1'b0, 8'h30, 8'h00, 8'h33, 1'b0, 1'b0, "collld-final");

    // Latency 0: ready at the accept edge, one pulse per request every 2 cycles.
    @(negedge clk);
    z_wv = 1'b1; z_wa = 8'h40; z_wd = 8'h90;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("l0-wready", 32'(z_wr), 32'd1);
      z_wv = 1'b0;
      @(negedge clk);
      chk("l0-wgap", 32'(z_wr), 32'd0);
      if (i < 3) begin z_wv = 1'b1; z_wa = 8'h41 + 8'(i); z_wd = 8'h91 + 8'(i); end
    end
    z_rv = 1'b1; z_ra = 8'h40;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("l0-rready", 32'(z_rr), 32'd1);
      chk("l0-rdata", 32'(z_rd), 32'(8'h90 + 8'(i)));
      z_rv = 1'b0;
      @(negedge clk);
      chk("l0-rgap", 32'(z_rr), 32'd0);
      if (i < 3) begin z_rv = 1'b1; z_ra = 8'h41 + 8'(i); end
    end
    chk("l0-counts", 32'({z_rc, z_wc}), 32'h00040004);

    // Randomized phase against the transaction-level model.
    begin
      bit r_act, w_act, r_cool, w_cool, r_fire, w_fire;
      int r_due, w_due;
      logic [7:0] r_a, w_a, w_d;
      r_act = 0; w_act = 0; r_cool = 0; w_cool = 0; r_due = 0; w_due = 0;
      r_a = 8'h00; w_a = 8'h00; w_d = 8'h00;
      for (int cyc = 0; cyc < 400; cyc++) begin
        le = ($urandom_range(0, 3) == 0); la = 8'($urandom_range(0, 7)); ld = 8'($urandom);
        if (r_act) begin
          ra = 8'($urandom);
          if ($urandom_range(0, 7) == 0) rv = 1'b0;
        end else if (!r_cool && cyc < 380 && $urandom_range(0, 1) == 1) begin
          rv = 1'b1; ra = 8'($urandom_range(0, 7)); r_a = ra; r_act = 1; r_due = cyc + RL;
        end
        if (w_act) begin
          wa = 8'($urandom); wd = 8'($urandom);
          if ($urandom_range(0, 7) == 0) wv = 1'b0;
        end else if (!w_cool && cyc < 380 && $urandom_range(0, 1) == 1) begin
          wv = 1'b1; wa = 8'($urandom_range(0, 7)); wd = 8'($urandom); w_a = wa; w_d = wd;
          w_act = 1; w_due = cyc + WL;
        end
        @(posedge clk);
        r_fire = r_act && (r_due == cyc);
        w_fire = w_act && (w_due == cyc);
        if (r_fire) begin last_rd = mm[r_a]; exp_rc = sat_inc(exp_rc); end
        if (w_fire) begin mm[w_a] = w_d; exp_wc = sat_inc(exp_wc); end
        if (le) mm[la] = ld;
        @(negedge clk);
        chk("rnd-rready", 32'(rr), 32'(r_fire));
        chk("rnd-wready", 32'(wr), 32'(w_fire));
        chk("rnd-rdata", 32'(rd_o), 32'(last_rd));
        chk("rnd-counts", 32'({rc, wc}), 32'({exp_rc, exp_wc}));
        if (r_fire) begin r_act = 0; rv = 1'b0; end
        if (w_fire) begin w_act = 0; wv = 1'b0; end
        r_cool = r_fire;
        w_cool = w_fire;
      end
      le = 1'b0; rv = 1'b0; wv = 1'b0;
      @(negedge clk);
    end

    // Read counter saturation from a preset value.
    @(negedge clk);
    force dut.r_read_count = 16'hFFFD;
    @(negedge clk);
    release dut.r_read_count;
    exp_rc = 16'hFFFD;
    @(negedge clk);
    chk("sat-preset", 32'(rc), 32'hFFFD);
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, 8'(i), 8'h00, mm[i], 1'b0, 1'b0, "sat-read");
    end
    chk("sat-final", 32'(rc), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
